// File: rtl/conv2_sequencer.sv
// conv2_sequencer: address/enable sequencer for the KxK valid conv2 layer over the packed pooled map.
module conv2_sequencer #(
  parameter int IN_W    = 14,
  parameter int K       = 5,
  parameter int OUT_CH  = 16,
  parameter int RD_LAT  = 2,
  parameter int RES_LAT = 3,
  parameter int PIC_AW  = 10,
  parameter int W_AW    = 9,
  parameter int B_AW    = 4,
  parameter int OUT_AW  = 11
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  output logic              ena_pic,
  output logic [PIC_AW-1:0] addr_pic,
  output logic              ena_w,
  output logic [W_AW-1:0]   addr_w,
  output logic              ena_bias,
  output logic [B_AW-1:0]   addr_bias,
  output logic              bias_load,
  output logic              mac_valid,
  output logic              mac_first,
  output logic              mac_last,
  output logic              out_we,
  output logic [OUT_AW-1:0] addr_out,
  output logic              busy,
  output logic              done
);
  localparam int OUT_W = IN_W - K + 1;
  localparam int OCW = $clog2(OUT_CH + 1);
  localparam int PW = $clog2(OUT_W + 1);
  localparam int KW = $clog2(K + 1);
  localparam int CW = $clog2(RD_LAT + RES_LAT + 1);
  typedef enum logic [2:0] {IDLE, BIAS, TAPS, FLUSH, WRITE, DONE} state_t;
  state_t st, st_n;
  logic [OCW-1:0] oc, oc_n;
  logic [PW-1:0] oy, oy_n, ox, ox_n;
  logic [KW-1:0] ky, ky_n, kx, kx_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [RD_LAT-1:0] v_sr, f_sr, l_sr;
  logic kx_end, ky_end, ox_end, oy_end, oc_end, tap_first, tap_last;
  assign kx_end = int'(kx) == K - 1;
  assign ky_end = int'(ky) == K - 1;
  assign ox_end = int'(ox) == OUT_W - 1;
  assign oy_end = int'(oy) == OUT_W - 1;
  assign oc_end = int'(oc) == OUT_CH - 1;
  assign tap_first = st == TAPS && ky == '0 && kx == '0;
  assign tap_last = st == TAPS && kx_end && ky_end;
  always_comb begin
    st_n = st;
    oc_n = oc;
    oy_n = oy;
    ox_n = ox;
    ky_n = ky;
    kx_n = kx;
    cnt_n = cnt + 1'b1;
    case (st)
      IDLE: begin
        cnt_n = '0;
        if (start) begin
          st_n = BIAS;
          oc_n = '0;
          oy_n = '0;
          ox_n = '0;
          ky_n = '0;
          kx_n = '0;
        end
      end
      BIAS: if (int'(cnt) == RD_LAT - 1) begin
        st_n = TAPS;
        cnt_n = '0;
      end
      TAPS: begin
        kx_n = kx_end ? '0 : kx + 1'b1;
        ky_n = !kx_end ? ky : ky_end ? '0 : ky + 1'b1;
        if (tap_last) begin
          st_n = FLUSH;
          cnt_n = '0;
        end
      end
      FLUSH: if (int'(cnt) == RD_LAT + RES_LAT - 1) begin
        st_n = WRITE;
        cnt_n = '0;
      end
      WRITE: begin
        cnt_n = '0;
        ox_n = ox_end ? '0 : ox + 1'b1;
        oy_n = !ox_end ? oy : oy_end ? '0 : oy + 1'b1;
        oc_n = (ox_end && oy_end) ? oc + 1'b1 : oc;
        st_n = !(ox_end && oy_end) ? TAPS : oc_end ? DONE : BIAS;
      end
      default: st_n = IDLE;
    endcase
    if (abort) st_n = IDLE;
  end
  // Addresses are loaded from the next-cycle counters so they line up with the enables.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st <= IDLE;
      oc <= '0;
      oy <= '0;
      ox <= '0;
      ky <= '0;
      kx <= '0;
      cnt <= '0;
      v_sr <= '0;
      f_sr <= '0;
      l_sr <= '0;
      addr_pic <= '0;
      addr_w <= '0;
      addr_bias <= '0;
      addr_out <= '0;
    end else begin
      st <= st_n;
      oc <= oc_n;
      oy <= oy_n;
      ox <= ox_n;
      ky <= ky_n;
      kx <= kx_n;
      cnt <= cnt_n;
      v_sr <= abort ? '0 : (v_sr << 1) | RD_LAT'(st == TAPS);
      f_sr <= abort ? '0 : (f_sr << 1) | RD_LAT'(tap_first);
      l_sr <= abort ? '0 : (l_sr << 1) | RD_LAT'(tap_last);
      if (st_n == BIAS) addr_bias <= B_AW'(oc_n);
      if (st_n == TAPS) begin
        addr_pic <= PIC_AW'((int'(oy_n) + int'(ky_n)) * IN_W + int'(ox_n) + int'(kx_n));
        addr_w <= W_AW'(int'(oc_n) * K * K + int'(ky_n) * K + int'(kx_n));
      end
      if (st_n == WRITE) addr_out <= OUT_AW'(int'(oc) * OUT_W * OUT_W + int'(oy) * OUT_W + int'(ox));
    end
  end
  assign busy = st != IDLE;
  assign ena_bias = st == BIAS && cnt == '0;
  assign bias_load = st == BIAS && int'(cnt) == RD_LAT - 1;
  assign ena_pic = st == TAPS;
  assign ena_w = st == TAPS;
  assign out_we = st == WRITE;
  assign done = st == DONE;
  assign mac_valid = v_sr[RD_LAT-1];
  assign mac_first = f_sr[RD_LAT-1];
  assign mac_last = l_sr[RD_LAT-1];
endmodule

// File: tb/tb_conv2_sequencer.sv
// tb_conv2_sequencer: vector table, closed-form timeline model, abort/reset corner sequences.
module tb_conv2_sequencer;
  localparam int TOTAL = 49633;
  localparam int CH = 3102;
  localparam int PX = 31;
  logic clk = 0, rst = 1, start = 0, abort = 0;
  logic ena_pic, ena_w, ena_bias, bias_load, mac_valid, mac_first, mac_last, out_we, busy, done;
  logic [9:0] addr_pic;
  logic [8:0] addr_w;
  logic [3:0] addr_bias;
  logic [10:0] addr_out;
  logic [9:0] ctl;
  int checks = 0, errors = 0;
  conv2_sequencer dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .ena_pic(ena_pic), .addr_pic(addr_pic), .ena_w(ena_w), .addr_w(addr_w),
    .ena_bias(ena_bias), .addr_bias(addr_bias), .bias_load(bias_load),
    .mac_valid(mac_valid), .mac_first(mac_first), .mac_last(mac_last),
    .out_we(out_we), .addr_out(addr_out), .busy(busy), .done(done)
  );
  always #5 clk = ~clk;
  assign ctl = {busy, ena_bias, bias_load, ena_pic, ena_w, mac_valid, mac_first, mac_last, out_we, done};
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask
  // Cycle t after the start edge: kind 0/1 bias cycles, 2 tap, 3 flush, 4 write, 5 done, 6 idle.
  function automatic void dec(input int t, output int kind, output int oc, output int p, output int q);
    int u, r;
    kind = 6; oc = 0; p = 0; q = 0;
    if (t < 1 || t > TOTAL) return;
    if (t == TOTAL) begin kind = 5; return; end
    u = t - 1; oc = u / CH; r = u % CH;
    if (r < 2) kind = r;
    else begin
      p = (r - 2) / PX; q = (r - 2) % PX;
      kind = q < 25 ? 2 : q < 30 ? 3 : 4;
    end
  endfunction
  function automatic logic [9:0] exp_ctl(input int t);
    int k, oc, p, q, kp, ocp, pp, qp;
    dec(t, k, oc, p, q);
    dec(t - 2, kp, ocp, pp, qp);
    return {t >= 1 && t <= TOTAL, k == 0, k == 1, k == 2, k == 2, kp == 2,
            kp == 2 && qp == 0, kp == 2 && qp == 24, k == 4, k == 5};
  endfunction
  task automatic run(input int abort_at, input bit noise, input bit full);
    int k, oc, p, q, te, nwe, epic;
    bit ab;
    start = 1; abort = 0;
    @(posedge clk); #1;
    start = 0; nwe = 0; epic = 0; ab = 0;
    for (int t = 1; t <= TOTAL + 2; t++) begin
      te = ab ? 0 : t;
      chk("ctl", ctl, exp_ctl(te));
      dec(te, k, oc, p, q);
      if (k == 0) chk("addr_bias", addr_bias, oc);
      if (k == 2) begin
        epic = (p / 10 + q / 5) * 14 + p % 10 + q % 5;
        chk("addr_pic", addr_pic, epic);
        chk("addr_w", addr_w, oc * 25 + q);
      end
      if (k == 3) chk("pic_hold", addr_pic, epic);
      if (k == 4) chk("addr_out", addr_out, oc * 100 + p);
      nwe += int'(out_we);
      if (ab && t > abort_at + 3) break;
      start = noise && !ab && t <= TOTAL && $urandom_range(0, 15) == 0;
      abort = t == abort_at;
      if (t == abort_at) ab = 1;
      @(posedge clk); #1;
    end
    start = 0; abort = 0;
    if (full) chk("we_count", nwe, 1600);
  endtask
  typedef struct {
    logic start, abort;
    logic [9:0] ctl, apic;
    logic [3:0] abias;
  } vec_t;
  vec_t tv[9];
  initial begin
    tv[0] = '{1'b0, 1'b0, 10'b0000000000, 10'd0, 4'd0};
    tv[1] = '{1'b1, 1'b1, 10'b0000000000, 10'd0, 4'd0};
    tv[2] = '{1'b1, 1'b0, 10'b1100000000, 10'd0, 4'd0};
    tv[3] = '{1'b0, 1'b0, 10'b1010000000, 10'd0, 4'd0};
    tv[4] = '{1'b0, 1'b0, 10'b1001100000, 10'd0, 4'd0};
    tv[5] = '{1'b0, 1'b0, 10'b1001100000, 10'd1, 4'd0};
    tv[6] = '{1'b1, 1'b0, 10'b1001111000, 10'd2, 4'd0};
    tv[7] = '{1'b0, 1'b1, 10'b0000000000, 10'd2, 4'd0};
    tv[8] = '{1'b0, 1'b0, 10'b0000000000, 10'd2, 4'd0};
    repeat (2) @(posedge clk);
    #1;
    chk("reset_ctl", ctl, 0);
    chk("reset_addr", {addr_pic, addr_w, addr_bias, addr_out}, 0);
    rst = 0;
    for (int i = 0; i < 9; i++) begin
      start = tv[i].start; abort = tv[i].abort;
      @(posedge clk); #1;
      chk($sformatf("vec%0d_ctl", i), ctl, tv[i].ctl);
      chk($sformatf("vec%0d_pic", i), addr_pic, tv[i].apic);
      chk($sformatf("vec%0d_bias", i), addr_bias, tv[i].abias);
    end
    start = 0; abort = 0;
    start = 1;
    @(posedge clk); #1;
    start = 0;
    repeat (49) @(posedge clk);
    #1;
    chk("mid_ena_pic", ena_pic, 1);
    #2 rst = 1;
    #1;
    chk("async_rst_ctl", ctl, 0);
    chk("async_rst_addr", {addr_pic, addr_w}, 0);
    start = 1;
    @(posedge clk); #1;
    chk("rst_start_busy", busy, 0);
    rst = 0; start = 0;
    @(posedge clk); #1;
    chk("post_rst_idle", ctl, 0);
    run(0, 1, 1);
    run(3 + 37 * PX + 10, 0, 0);
    run(int'($urandom_range(1, 4000)), 1, 0);
    run(int'($urandom_range(1, 4000)), 1, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
